i2c_command_scheduler: RTL

//  Sequences all camera register writes through i2c_module: replays the fixed 8-entry startup table after

---
 rtl/i2c_command_scheduler_if.sv | 28 ++
 rtl/i2c_command_scheduler.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/i2c_command_scheduler_if.sv
// Request/ack handshake and i2c_module command bus of the I2C command scheduler.
// The scheduler takes the slave modport; requesters and i2c_module sit on the master side.
interface i2c_command_scheduler_if;
  logic        restart_init;
  logic        req0;
  logic        req1;
  logic [7:0]  reg0;
  logic [7:0]  reg1;
  logic [15:0] data0;
  logic [15:0] data1;
  logic        ack0;
  logic        ack1;
  logic        i2c_send;
  logic [7:0]  i2c_register;
  logic [15:0] i2c_data;
  logic        busy;
  logic        init_done;

  modport slave (
    input  restart_init, req0, req1, reg0, reg1, data0, data1,
    output ack0, ack1, i2c_send, i2c_register, i2c_data, busy, init_done
  );

  modport master (
    output restart_init, req0, req1, reg0, reg1, data0, data1,
    input  ack0, ack1, i2c_send, i2c_register, i2c_data, busy, init_done
  );
endinterface

// File: rtl/i2c_command_scheduler.sv
// Replays the camera startup table after power-up, then round-robins host and auto-exposure
// register writes onto the single i2c_module write path, timing each command by cycle counts.
module i2c_command_scheduler #(
  parameter int unsigned BOOT_DELAY   = 1000000,
  parameter int unsigned PULSE_CYCLES = 4,
  parameter int unsigned TXN_CYCLES   = 450000,
  parameter int unsigned GAP_CYCLES   = 50000
) (
  input  logic                   clk,
  input  logic                   reset_n,
  i2c_command_scheduler_if.slave bus
);
  localparam logic [2:0] S_BOOT   = 3'd0;
  localparam logic [2:0] S_SELECT = 3'd1;
  localparam logic [2:0] S_ISSUE  = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_GAP    = 3'd4;

  localparam logic [1:0] G_TABLE = 2'd0;
  localparam logic [1:0] G_REQ0  = 2'd1;
  localparam logic [1:0] G_REQ1  = 2'd2;

  localparam logic [31:0] BOOT_LAST  = 32'(BOOT_DELAY - 1);
  localparam logic [31:0] PULSE_LAST = 32'(PULSE_CYCLES - 1);
  localparam logic [31:0] TXN_LAST   = 32'(TXN_CYCLES - 1);
  localparam logic [31:0] GAP_LAST   = 32'(GAP_CYCLES - 1);
  localparam logic [3:0]  TABLE_LEN  = 4'd8;

  function automatic logic [23:0] table_entry(input logic [2:0] idx);
    case (idx)
      3'd0:    table_entry = {8'h23, 16'h0033};
      3'd1:    table_entry = {8'h23, 16'h0033};
      3'd2:    table_entry = {8'h22, 16'h0033};
      3'd3:    table_entry = {8'h04, 16'h09FF};
      3'd4:    table_entry = {8'h03, 16'h077F};
      3'd5:    table_entry = {8'h01, 16'h0038};
      3'd6:    table_entry = {8'h20, 16'h0060};
      default: table_entry = {8'h1E, 16'h4146};
    endcase
  endfunction

  logic [2:0]  state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [3:0]  idx_q, idx_d, idx_sel;
  logic        rr_q, rr_d;            // 1: req1 has priority on the next tie
  logic [1:0]  gnt_q, gnt_d;
  logic        restart_q, restart_d;
  logic [7:0]  reg_q, reg_d;
  logic [15:0] data_q, data_d;
  logic        send_q, send_d;
  logic        ack0_q, ack0_d;
  logic        ack1_q, ack1_d;
  logic        init_done_q, init_done_d;

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + 32'd1;
    idx_d       = idx_q;
    idx_sel     = idx_q;
    rr_d        = rr_q;
    gnt_d       = gnt_q;
    restart_d   = restart_q | bus.restart_init;
    reg_d       = reg_q;
    data_d      = data_q;
    send_d      = 1'b0;
    ack0_d      = 1'b0;
    ack1_d      = 1'b0;
    init_done_d = init_done_q;

    case (state_q)
      S_BOOT: begin
        if (cnt_q == BOOT_LAST) begin
          state_d = S_SELECT;
          cnt_d   = '0;
        end
      end
      S_SELECT: begin
        cnt_d = '0;
        // A pending replay is only ever honoured here, between commands.
        if (restart_d) begin
          idx_sel     = '0;
          restart_d   = 1'b0;
          init_done_d = 1'b0;
        end
        if (idx_sel < TABLE_LEN) begin
          {reg_d, data_d} = table_entry(idx_sel[2:0]);
          idx_d   = idx_sel;
          gnt_d   = G_TABLE;
          send_d  = 1'b1;
          state_d = S_ISSUE;
        end else begin
          init_done_d = 1'b1;
          if (bus.req0 && (!rr_q || !bus.req1)) begin
            reg_d   = bus.reg0;
            data_d  = bus.data0;
            gnt_d   = G_REQ0;
            send_d  = 1'b1;
            state_d = S_ISSUE;
          end else if (bus.req1) begin
            reg_d   = bus.reg1;
            data_d  = bus.data1;
            gnt_d   = G_REQ1;
            send_d  = 1'b1;
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        send_d = 1'b1;
        if (cnt_q == PULSE_LAST) begin
          send_d  = 1'b0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // The counter keeps running from ISSUE entry, so this marks the full transaction time.
        if (cnt_q == TXN_LAST) begin
          state_d = S_GAP;
          cnt_d   = '0;
          case (gnt_q)
            G_REQ0:  begin ack0_d = 1'b1; rr_d = 1'b1; end
            G_REQ1:  begin ack1_d = 1'b1; rr_d = 1'b0; end
            default: idx_d = idx_q + 4'd1;
          endcase
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = S_SELECT;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = S_BOOT;
        cnt_d   = '0;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_BOOT;
      cnt_q       <= '0;
      idx_q       <= '0;
      rr_q        <= 1'b0;
      gnt_q       <= G_TABLE;
      restart_q   <= 1'b0;
      reg_q       <= '0;
      data_q      <= '0;
      send_q      <= 1'b0;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      rr_q        <= rr_d;
      gnt_q       <= gnt_d;
      restart_q   <= restart_d;
      reg_q       <= reg_d;
      data_q      <= data_d;
      send_q      <= send_d;
      ack0_q      <= ack0_d;
      ack1_q      <= ack1_d;
      init_done_q <= init_done_d;
    end
  end

  assign bus.i2c_send     = send_q;
  assign bus.i2c_register = reg_q;
  assign bus.i2c_data     = data_q;
  assign bus.ack0         = ack0_q;
  assign bus.ack1         = ack1_q;
  assign bus.init_done    = init_done_q;
  assign bus.busy         = (state_q == S_ISSUE) || (state_q == S_WAIT) || (state_q == S_GAP);
endmodule
